// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS32 general-purpose register file.
package regfile_pkg;

   localparam int unsigned RegBus     = 32;
   localparam int unsigned RegAddrBus = 5;
   localparam int unsigned RegNum     = 32;
   localparam int unsigned RegNumLog2 = 5;

   localparam logic [RegBus-1:0]     ZeroWord    = 32'h0000_0000;
   localparam logic                  RstEnable   = 1'b1;
   localparam logic                  WriteEnable = 1'b1;
   localparam logic                  ReadEnable  = 1'b1;
   localparam logic [RegAddrBus-1:0] NOPRegAddr  = 5'b00000;

endpackage : regfile_pkg

// File: rtl/regfile.sv
// 32x32 register file: one write port, two combinational read ports with
// same-cycle write-to-read bypass; register 0 is hardwired to zero.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = RegBus,
   parameter int unsigned ADDR_W = RegNumLog2,
   parameter int unsigned NREG   = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   // Read port selection; earlier conditions take priority.
   function automatic logic [DATA_W-1:0] read_port(
      input logic              rst_v,
      input logic              re_v,
      input logic [ADDR_W-1:0] raddr_v,
      input logic [DATA_W-1:0] stored_v,
      input logic              we_v,
      input logic [ADDR_W-1:0] waddr_v,
      input logic [DATA_W-1:0] wdata_v
   );
      logic [DATA_W-1:0] res;
      if (rst_v == RstEnable) begin
         res = {DATA_W{1'b0}};
      end else if (raddr_v == {ADDR_W{1'b0}}) begin
         res = {DATA_W{1'b0}};
      end else if ((re_v == ReadEnable) && (we_v == WriteEnable) && (raddr_v == waddr_v)) begin
         res = wdata_v;
      end else if (re_v == ReadEnable) begin
         res = stored_v;
      end else begin
         res = {DATA_W{1'b0}};
      end
      return res;
   endfunction

   always_comb begin
      regs_d = regs_q;
      if ((we == WriteEnable) && (waddr != {ADDR_W{1'b0}})) begin
         regs_d[waddr] = wdata;
      end else begin
         regs_d[0] = {DATA_W{1'b0}};
      end
   end

   // Reset clears every entry and drops any coincident write.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata1 = read_port(rst, re1, raddr1, regs_q[raddr1], we, waddr, wdata);
      rdata2 = read_port(rst, re2, raddr2, regs_q[raddr2], we, waddr, wdata);
   end

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic compared against an array model of the architectural registers.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst, we, re1, re2;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata, rdata1, rdata2;

   logic [31:0] model [32];
   int          total  = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   regfile dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   function automatic logic [31:0] expect_read(input logic e, input logic [4:0] a);
      if (rst)                      return 32'h0;
      if (a == 5'd0)                return 32'h0;
      if (!e)                       return 32'h0;
      if (we && (a == waddr))       return wdata;
      return model[a];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at the falling edge, check reads mid-cycle, then let the edge commit.
   task automatic cycle(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                        input string tag);
      @(negedge clk);
      rst = r; we = w; waddr = wa; wdata = wd;
      re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
      #2;
      check({tag, ".p1"}, rdata1, expect_read(e1, a1));
      check({tag, ".p2"}, rdata2, expect_read(e2, a2));
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (w && (wa != 5'd0)) begin
         model[wa] = wd;
      end
   endtask

   initial begin
      logic        r, w, e1, e2;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;

      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
      re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

      cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2, "reset_hold");
      for (int i = 0; i < 32; i++)
         cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i), "post_reset_zero");

      // Reset clears a preloaded register.
      cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, "preload5");
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, "preload5_rd");
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, "rst_clear");
      check("rst_clear_const", rdata1, 32'h0);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, "after_rst5");

      // Basic write then read.
      cycle(1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd3, 1'b0, 5'd3, "wr3");
      cycle(1'b0, 1'b0, 5'd3, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, "rd3");
      check("rd3_const", rdata1, 32'h12345678);

      // Dual bypass over a stale value.
      cycle(1'b0, 1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 1'b0, 5'd0, "wr7_old");
      cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7, "bypass7");
      check("bypass7_const", rdata2, 32'hA5A5A5A5);
      cycle(1'b0, 1'b0, 5'd7, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, "stored7");
      check("stored7_const", rdata1, 32'hA5A5A5A5);

      // Register 0 ignores writes and is never bypassed.
      cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, "r0_wr");
      check("r0_bypass_const", rdata1, 32'h0);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, "r0_after");

      // Read enable gating.
      cycle(1'b0, 1'b1, 5'd9, 32'h00000055, 1'b0, 5'd0, 1'b0, 5'd9, "wr9");
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b0, 5'd9, "re2_off");
      check("re2_off_const", rdata2, 32'h0);
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, "re2_on");
      check("re2_on_const", rdata2, 32'h00000055);

      // Write coinciding with reset is lost and not bypassed.
      cycle(1'b1, 1'b1, 5'd4, 32'h00000099, 1'b1, 5'd4, 1'b1, 5'd4, "rst_wr4");
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4, "after_rst4");
      check("after_rst4_const", rdata1, 32'h0);

      // Back-to-back writes to one address.
      cycle(1'b0, 1'b1, 5'd12, 32'h11111111, 1'b1, 5'd12, 1'b1, 5'd12, "b2b_a");
      cycle(1'b0, 1'b1, 5'd12, 32'h22222222, 1'b1, 5'd12, 1'b1, 5'd12, "b2b_b");
      cycle(1'b0, 1'b0, 5'd12, 32'h0, 1'b1, 5'd12, 1'b1, 5'd31, "b2b_rd");

      // Random traffic; read addresses often collide with the write address.
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 39) == 0);
         w  = ($urandom_range(0, 1) == 1);
         wa = 5'($urandom_range(0, 31));
         wd = $urandom;
         e1 = ($urandom_range(0, 3) != 0);
         e2 = ($urandom_range(0, 3) != 0);
         a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         cycle(r, w, wa, wd, e1, a1, e2, a2, "rand");
      end

      // Final sweep of the whole array against the model.
      for (int i = 0; i < 32; i++)
         cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i), "sweep");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_regfile
